// File: rtl/bcu_pkg.sv
// bcu_pkg: shared state encoding, default word width and address-width helpers for the batch control unit
package bcu_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_CAPTURE,
        S_STORE,
        S_FINISH
    } state_e;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return idx_w(depth) + 1;
    endfunction

endpackage

// File: rtl/bcu_lane_serializer.sv
// bcu_lane_serializer: captures one batch of core lanes and shifts them out one word per cycle with a last-word flag
module bcu_lane_serializer
    import bcu_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_i,
    input  logic                      load_i,
    input  logic                      shift_i,
    input  logic [LANES*DATA_W-1:0]   lanes_i,
    output logic [DATA_W-1:0]         word_o,
    output logic                      last_o
);

    localparam int CW = idx_w(LANES);

    logic [LANES*DATA_W-1:0] lanes_q;
    logic [CW-1:0]           cnt_q;

    // lane 0 always sits at the bottom; each shift exposes the next lane and advances the word index
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            lanes_q <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            lanes_q <= lanes_i;
            cnt_q   <= '0;
        end else if (shift_i) begin
            lanes_q <= lanes_q >> DATA_W;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign word_o = lanes_q[DATA_W-1:0];
    assign last_o = cnt_q == CW'(LANES - 1);

endmodule

// File: rtl/batch_control_unit.sv
// batch_control_unit: loads host words, runs the compute core once per word, stores LANES results per batch
// Optional watchdog on RUN/WAIT enabled by defining BCU_WDOG_EN.
module batch_control_unit
    import bcu_pkg::*;
#(
    parameter int LANES       = 8,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int IN_DEPTH    = 32,
    parameter int OUT_DEPTH   = 32,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rstmaster,
    input  logic                          rdy_data,
    input  logic                          start,
    input  logic                          core_done,
    input  logic [LANES*DATA_W-1:0]       lanes_in,
    output logic                          core_rst,
    output logic [idx_w(IN_DEPTH)-1:0]    core_base,
    output logic                          in_we,
    output logic [cnt_w(IN_DEPTH)-1:0]    in_addr,
    output logic                          out_we,
    output logic [cnt_w(OUT_DEPTH)-1:0]   out_addr,
    output logic [DATA_W-1:0]             out_data,
    output logic                          busy,
    output logic                          batch_done,
    output logic                          ovf,
    output logic                          err
);

    localparam int AW  = idx_w(IN_DEPTH);
    localparam int IAW = cnt_w(IN_DEPTH);
    localparam int OAW = cnt_w(OUT_DEPTH);

    state_e             state_q, state_d;
    logic               rdy_q;
    logic [IAW-1:0]     in_addr_q, in_addr_d;
    logic [OAW-1:0]     out_addr_q, out_addr_d;
    logic [AW-1:0]      core_base_q, core_base_d;
    logic [IAW-1:0]     base_nxt;
    logic               ovf_q, ovf_d;
    logic               rdy_rise, run_wait, ld, sh, last;
    logic [DATA_W-1:0]  word;

`ifdef BCU_WDOG_EN
    localparam int WW = idx_w(WDOG_CYCLES);
    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d, abort_q, abort_d;
`endif

    assign rdy_rise = rdy_data & ~rdy_q;
    assign run_wait = (state_q == S_RUN) || (state_q == S_WAIT);
    assign base_nxt = IAW'(core_base_q) + 1'b1;

    // next-state and datapath updates; a batch ends when every loaded word is consumed or output memory is full
    always_comb begin
        state_d     = state_q;
        in_addr_d   = in_addr_q;
        out_addr_d  = out_addr_q;
        core_base_d = core_base_q;
        ovf_d       = ovf_q;
        ld          = 1'b0;
        sh          = 1'b0;
`ifdef BCU_WDOG_EN
        err_d       = err_q;
        abort_d     = abort_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rdy_rise) begin
                    if (in_addr_q < IAW'(IN_DEPTH)) state_d = S_LOAD;
                    else ovf_d = 1'b1;
                end else if (start && in_addr_q != '0) begin
                    state_d     = S_RUN;
                    core_base_d = '0;
                    out_addr_d  = '0;
                end
            end
            S_LOAD: begin
                in_addr_d = in_addr_q + 1'b1;
                state_d   = S_IDLE;
            end
            S_RUN:     state_d = core_done ? S_RUN : S_WAIT;
            S_WAIT:    state_d = core_done ? S_CAPTURE : S_WAIT;
            S_CAPTURE: begin
                ld      = 1'b1;
                state_d = S_STORE;
            end
            S_STORE: begin
                sh         = 1'b1;
                out_addr_d = out_addr_q + 1'b1;
                if (last) begin
                    core_base_d = base_nxt[AW-1:0];
                    state_d     = (base_nxt == in_addr_q || out_addr_d == OAW'(OUT_DEPTH)) ? S_FINISH : S_RUN;
                end
            end
            S_FINISH: begin
                in_addr_d = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef BCU_WDOG_EN
        if (run_wait && wdog_q == WW'(WDOG_CYCLES - 1)) begin
            state_d = S_FINISH;
            err_d   = 1'b1;
            abort_d = 1'b1;
        end
        if (state_q == S_FINISH) abort_d = 1'b0;
        wdog_d = (run_wait && state_d == state_q) ? wdog_q + 1'b1 : '0;
`endif
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rstmaster) begin
        if (rstmaster) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b0;
            in_addr_q   <= '0;
            out_addr_q  <= '0;
            core_base_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_data;
            in_addr_q   <= in_addr_d;
            out_addr_q  <= out_addr_d;
            core_base_q <= core_base_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef BCU_WDOG_EN
    // watchdog counter and sticky abort flags
    always_ff @(posedge clk or posedge rstmaster) begin
        if (rstmaster) begin
            wdog_q  <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end
    assign err        = err_q;
    assign batch_done = (state_q == S_FINISH) && !abort_q;
`else
    assign err        = 1'b0;
    assign batch_done = state_q == S_FINISH;
`endif

    bcu_lane_serializer #(
        .LANES  (LANES),
        .DATA_W (DATA_W)
    ) u_ser (
        .clk     (clk),
        .rst_i   (rstmaster),
        .load_i  (ld),
        .shift_i (sh),
        .lanes_i (lanes_in),
        .word_o  (word),
        .last_o  (last)
    );

    assign core_rst  = !run_wait;
    assign core_base = core_base_q;
    assign in_we     = state_q == S_LOAD;
    assign in_addr   = in_addr_q;
    assign out_we    = state_q == S_STORE;
    assign out_addr  = out_addr_q;
    assign out_data  = out_we ? word : '0;
    assign busy      = state_q != S_IDLE;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_batch_control_unit.sv
// tb_batch_control_unit: directed scenarios with a randomized core model and queue-based expected output stream
module tb_batch_control_unit;

    localparam int LANES  = 8;
    localparam int DATA_W = 32;

    logic                     clk = 1'b0;
    logic                     rstmaster, rdy_data, start, core_done;
    logic [LANES*DATA_W-1:0]  lanes_in;
    logic                     core_rst, in_we, out_we, busy, batch_done, ovf, err;
    logic [4:0]               core_base;
    logic [5:0]               in_addr, out_addr;
    logic [DATA_W-1:0]        out_data;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] cap_d[$];
    int                cap_a[$];
    int                cap_t[$];
    int                cyc = 0, ow_cnt = 0, iw_cnt = 0, bd_cnt = 0;
    int                lat = 1;
    bit                hang = 1'b0, fixed = 1'b0;

    batch_control_unit #(
        .LANES(LANES), .DATA_W(DATA_W), .IN_DEPTH(32), .OUT_DEPTH(32), .WDOG_CYCLES(16)
    ) dut (
        .clk(clk), .rstmaster(rstmaster), .rdy_data(rdy_data), .start(start),
        .core_done(core_done), .lanes_in(lanes_in), .core_rst(core_rst),
        .core_base(core_base), .in_we(in_we), .in_addr(in_addr), .out_we(out_we),
        .out_addr(out_addr), .out_data(out_data), .busy(busy), .batch_done(batch_done),
        .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    // compute core stand-in: after a random latency it raises done with a fresh set of lane results
    always @(posedge clk) begin
        #1;
        if (core_rst) begin
            core_done = 1'b0;
            lat = $urandom_range(1, 3);
        end else if (!core_done && !hang) begin
            if (lat == 0) begin
                for (int k = 0; k < LANES; k++) begin
                    lanes_in[k*DATA_W +: DATA_W] = fixed ? DATA_W'(32'hA0 + k) : $urandom;
                    exp_q.push_back(lanes_in[k*DATA_W +: DATA_W]);
                end
                core_done = 1'b1;
            end else lat--;
        end
    end

    // output-side observer
    always @(negedge clk) begin
        cyc++;
        if (out_we) begin
            cap_d.push_back(out_data);
            cap_a.push_back(int'(out_addr));
            cap_t.push_back(cyc);
            ow_cnt++;
        end
        if (in_we) iw_cnt++;
        if (batch_done) bd_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word;
        rdy_data = 1'b1;
        tick;
        rdy_data = 1'b0;
        tick;
        tick;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int b0 = bd_cnt;
        int n = 0;
        while (bd_cnt == b0 && n < bound) begin
            tick;
            n++;
        end
        chk(tag, 64'(bd_cnt - b0), 64'd1);
    endtask

    task automatic do_reset;
        rstmaster = 1'b1;
        hang = 1'b0;
        fixed = 1'b0;
        tick;
        tick;
        rstmaster = 1'b0;
        tick;
    endtask

    initial begin
        int e0, c0, ow0, iw0, bd0;
        rstmaster = 1'b1;
        rdy_data = 1'b0;
        start = 1'b0;
        core_done = 1'b0;
        lanes_in = '0;
        tick;
        tick;
        chk("rst_core_rst", core_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_in_we", in_we, 0);
        chk("rst_in_addr", in_addr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_core_base", core_base, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_flags", {batch_done, ovf, err}, 0);
        rstmaster = 1'b0;
        tick;

        pulse_start;
        for (int i = 0; i < 4; i++) begin
            chk("empty_start_busy", busy, 0);
            chk("empty_start_core_rst", core_rst, 1);
            tick;
        end

        iw0 = iw_cnt;
        for (int i = 0; i < 3; i++) load_word;
        chk("load3_in_addr", in_addr, 3);
        chk("load3_in_we", 64'(iw_cnt - iw0), 3);
        e0 = exp_q.size();
        c0 = cap_d.size();
        ow0 = ow_cnt;
        bd0 = bd_cnt;
        iw0 = iw_cnt;
        pulse_start;
        chk("run_busy", busy, 1);
        tick;
        tick;
        rdy_data = 1'b1;
        start = 1'b1;
        tick;
        rdy_data = 1'b0;
        start = 1'b0;
        wait_done("run3_done", 2000);
        chk("run3_out_we", 64'(ow_cnt - ow0), 24);
        chk("run3_batch_done", 64'(bd_cnt - bd0), 1);
        chk("run3_in_addr", in_addr, 0);
        chk("run3_busy_in_we", 64'(iw_cnt - iw0), 0);
        chk("run3_busy_ovf", ovf, 0);
        chk("run3_out_addr_end", out_addr, 24);
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("run3_addr%0d", i), 64'(cap_a[c0+i]), 64'(i));
            chk($sformatf("run3_data%0d", i), cap_d[c0+i], exp_q[e0+i]);
        end

        fixed = 1'b1;
        load_word;
        c0 = cap_d.size();
        pulse_start;
        wait_done("fixed_done", 500);
        chk("fixed_count", 64'(cap_d.size() - c0), 8);
        for (int i = 0; i < LANES; i++) begin
            chk($sformatf("fixed_data%0d", i), cap_d[c0+i], 64'(32'hA0 + i));
            chk($sformatf("fixed_cycle%0d", i), 64'(cap_t[c0+i] - cap_t[c0]), 64'(i));
        end
        fixed = 1'b0;

        for (int i = 0; i < 5; i++) load_word;
        e0 = exp_q.size();
        c0 = cap_d.size();
        ow0 = ow_cnt;
        pulse_start;
        wait_done("full_done", 3000);
        chk("full_out_we", 64'(ow_cnt - ow0), 32);
        chk("full_out_addr", out_addr, 32);
        chk("full_in_addr", in_addr, 0);
        chk("full_last_addr", 64'(cap_a[c0+31]), 31);
        for (int i = 0; i < 32; i += 7)
            chk($sformatf("full_data%0d", i), cap_d[c0+i], exp_q[e0+i]);

        hang = 1'b1;
        load_word;
        bd0 = bd_cnt;
        pulse_start;
        for (int i = 0; i < 40; i++) tick;
`ifdef BCU_WDOG_EN
        chk("wdog_err", err, 1);
        chk("wdog_core_rst", core_rst, 1);
        chk("wdog_busy", busy, 0);
        chk("wdog_no_batch_done", 64'(bd_cnt - bd0), 0);
`else
        chk("nowdog_err", err, 0);
        chk("nowdog_busy", busy, 1);
        chk("nowdog_core_rst", core_rst, 0);
        chk("nowdog_no_batch_done", 64'(bd_cnt - bd0), 0);
`endif
        do_reset;
        chk("post_hang_reset_err", err, 0);

        load_word;
        pulse_start;
        begin
            int n = 0;
            while (!out_we && n < 200) begin
                tick;
                n++;
            end
            chk("store_reached", out_we, 1);
        end
        tick;
        tick;
        tick;
        chk("store_cycle3_out_we", out_we, 1);
        rstmaster = 1'b1;
        #1;
        chk("midrst_out_we", out_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_core_rst", core_rst, 1);
        chk("midrst_addrs", {in_addr, out_addr, core_base}, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_flags", {batch_done, ovf, err}, 0);
        ow0 = ow_cnt;
        tick;
        rstmaster = 1'b0;
        for (int i = 0; i < 12; i++) tick;
        chk("midrst_no_more_we", 64'(ow_cnt - ow0), 0);
        chk("midrst_idle", busy, 0);

        iw0 = iw_cnt;
        for (int i = 0; i < 33; i++) load_word;
        chk("ovf_in_we", 64'(iw_cnt - iw0), 32);
        chk("ovf_flag", ovf, 1);
        chk("ovf_in_addr", in_addr, 32);
        chk("ovf_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/batch_control_unit.md
BATCH_CONTROL_UNIT -- requirements
Module: batch_control_unit

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  LANES, 8, result words returned by the core per batch.
  DATA_W, 32, word width.
  IN_DEPTH, 32, input-memory words.
  OUT_DEPTH, 32, output-memory words; SHALL be a multiple of LANES.
  WDOG_CYCLES, 1024, watchdog limit in clocks.
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk, in, 1, single clock.
  rstmaster, in, 1, asynchronous active-high reset.
  rdy_data, in, 1, host load strobe; one word per rising edge.
  start, in, 1, one-cycle pulse requesting a run.
  core_done, in, 1, compute-core completion level.
  lanes_in, in, LANES*DATA_W, core results; lane k at bits [k*DATA_W +: DATA_W].
  core_rst, out, 1, core hold-in-reset, active-high.
  core_base, out, clog2(IN_DEPTH), input index of the current batch.
  in_we, out, 1, input-memory write enable.
  in_addr, out, clog2(IN_DEPTH)+1, input write address / loaded count.
  out_we, out, 1, output-memory write enable.
  out_addr, out, clog2(OUT_DEPTH)+1, output write address.
  out_data, out, DATA_W, output write data.
  busy, out, 1, high in any state other than IDLE.
  batch_done, out, 1, one-cycle pulse when a run completes.
  ovf, out, 1, sticky load overflow.
  err, out, 1, sticky watchdog abort.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, RUN, WAIT, CAPTURE, STORE, FINISH, each registered on clk.
REQ-004 In IDLE, a rising edge of rdy_data (registered compare) with in_addr<IN_DEPTH SHALL move to LOAD.
REQ-005 In LOAD, in_we SHALL be 1 for exactly one cycle at in_addr; in_addr SHALL increment the following cycle; the FSM SHALL then return to IDLE.
REQ-006 A rdy_data edge with in_addr==IN_DEPTH SHALL set ovf, SHALL NOT write, and SHALL remain in IDLE.
REQ-007 start in IDLE with in_addr>0 SHALL move to RUN with core_base=0 and out_addr=0; start with in_addr==0 SHALL be ignored.
REQ-008 start outside IDLE SHALL be ignored.
REQ-009 In RUN, core_rst SHALL be 0; RUN SHALL move to WAIT when core_done==0.
REQ-010 In WAIT, core_rst SHALL be 0; WAIT SHALL move to CAPTURE when core_done==1.
REQ-011 CAPTURE SHALL last one cycle, latch all LANES words of lanes_in, and drive core_rst=1.
REQ-012 STORE SHALL last LANES cycles with out_we=1 and out_data=lane j on cycle j; out_addr SHALL increment after each write.
REQ-013 After STORE, core_base SHALL increment; if core_base==in_addr or out_addr==OUT_DEPTH the FSM SHALL go to FINISH, otherwise to RUN.
REQ-014 FINISH SHALL pulse batch_done for one cycle, clear in_addr to 0, and return to IDLE.
REQ-015 rdy_data while busy SHALL be ignored and SHALL NOT set ovf.
REQ-016 All address arithmetic SHALL be unsigned; out_addr SHALL never exceed OUT_DEPTH (no wrap).

Reset
REQ-017 rstmaster=1 SHALL asynchronously force: IDLE; core_rst=1; in_we=out_we=0; in_addr=out_addr=core_base=0; out_data=0; busy=batch_done=0; ovf=err=0; lane registers=0.
REQ-018 Reset asserted mid-STORE SHALL abort the batch with no further out_we pulse.

Configuration
REQ-019 With BCU_WDOG_EN defined, a counter SHALL run in RUN/WAIT and clear on state exit.
REQ-020 With BCU_WDOG_EN defined, reaching WDOG_CYCLES SHALL set err, force core_rst=1, and go to FINISH without batch_done.
REQ-021 Without BCU_WDOG_EN, there SHALL be no counter, err SHALL be tied to 0, and WAIT SHALL be unbounded.

Structure
REQ-022 Package bcu_pkg SHALL hold the state enum, the DATA_W default, and the address-width functions.
REQ-023 Sub-module bcu_lane_serializer SHALL hold the lane capture registers and the STORE counter (load, shift, last-flag).

Verification
REQ-024 Load 3 words (rdy_data edges), then start; core toggles done -> 3 batches, 24 out_we pulses, out_addr 0..23, one batch_done, in_addr=0.
REQ-025 33 rdy_data edges with IN_DEPTH=32 -> 32 in_we pulses, ovf=1, in_addr=32.
REQ-026 start with in_addr=0 -> busy stays 0, core_rst stays 1.
REQ-027 lanes_in = k+0xA0 in lane k -> out_data sequence 0xA0..0xA7 on consecutive cycles.
REQ-028 BCU_WDOG_EN, WDOG_CYCLES=16, core_done held 0 -> err=1 after 16 WAIT cycles, no batch_done, core_rst=1.
REQ-029 rstmaster pulsed on STORE cycle 3 -> out_we=0 immediately, all outputs at reset values.
